// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the pipeline's Memory-stage port.
//   Loads are combinational. Stores are posted through a 1-entry write buffer,
//   and loads forward buffered bytes so a store is visible from the next cycle.
//   A small MMIO window holds a console tohost register and a free-running
//   cycle counter.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-low reset (0 = reset)
//   memWE        store request this cycle
//   memcontrol   funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr         byte address
//   writedata    store data, bytes taken from the LSBs
//   readdata     load result, size/sign extended, combinational
//   misaligned   current access is misaligned, combinational
//   err_sticky   set by any misaligned access, cleared only by reset
//   tohost_valid one-cycle pulse after a word store to the TOHOST register
//   tohost_data  data of the last TOHOST store
module data_mem_responder #(
   parameter int          AW        = 10,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memWE,
   input  logic [2:0]  memcontrol,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        misaligned,
   output logic        err_sticky,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
);

   localparam logic [2:0]  F_B  = 3'b000;
   localparam logic [2:0]  F_H  = 3'b001;
   localparam logic [2:0]  F_W  = 3'b010;
   localparam logic [2:0]  F_BU = 3'b100;
   localparam logic [2:0]  F_HU = 3'b101;
   localparam logic [31:0] CYCLE_ADDR = MMIO_BASE + 32'd4;

   logic [31:0]   ram_q [2**AW];

   logic          wb_valid_q, wb_valid_d;
   logic [AW-1:0] wb_idx_q, wb_idx_d;
   logic [3:0]    wb_mask_q, wb_mask_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          tohost_valid_q, tohost_valid_d;
   logic [31:0]   tohost_data_q, tohost_data_d;
   logic          err_q, err_d;
   logic [31:0]   cycle_cnt_q, cycle_cnt_d;

   logic          is_mmio;
   logic [AW-1:0] ram_idx;
   logic [1:0]    lane;
   logic          op_valid;
   logic          mis_c;
   logic          store_ok;
   logic [31:0]   merged;
   logic [31:0]   src_word;
   logic [31:0]   shifted;
   logic [31:0]   load_c;

   // Address decode and alignment check. Unknown funct3 codes are treated as
   // no-ops, so they never flag misalignment.
   always_comb begin
      is_mmio  = (addr >= MMIO_BASE);
      ram_idx  = addr[AW+1:2];
      lane     = addr[1:0];
      op_valid = 1'b0;
      mis_c    = 1'b0;
      case (memcontrol)
         F_B, F_BU: op_valid = 1'b1;
         F_H, F_HU: begin
            op_valid = 1'b1;
            mis_c    = addr[0];
         end
         F_W: begin
            op_valid = 1'b1;
            mis_c    = (addr[1:0] != 2'b00);
         end
         default: op_valid = 1'b0;
      endcase
      store_ok = memWE && op_valid && !mis_c;
   end

   // Load path: RAM word overlaid with any buffered bytes for the same word,
   // or the selected MMIO register, then lane-shifted and extended.
   always_comb begin
      merged = ram_q[ram_idx];
      for (int i = 0; i < 4; i++) begin
         if (wb_valid_q && (wb_idx_q == ram_idx) && wb_mask_q[i]) begin
            merged[8*i +: 8] = wb_data_q[8*i +: 8];
         end
      end
      if (!is_mmio) begin
         src_word = merged;
      end else if (addr[31:2] == MMIO_BASE[31:2]) begin
         src_word = tohost_data_q;
      end else if (addr[31:2] == CYCLE_ADDR[31:2]) begin
         src_word = cycle_cnt_q;
      end else begin
         src_word = 32'h0;
      end
      shifted = src_word >> {lane, 3'b000};
      load_c  = 32'h0;
      if (!mis_c) begin
         case (memcontrol)
            F_B:     load_c = {{24{shifted[7]}}, shifted[7:0]};
            F_BU:    load_c = {24'h0, shifted[7:0]};
            F_H:     load_c = {{16{shifted[15]}}, shifted[15:0]};
            F_HU:    load_c = {16'h0, shifted[15:0]};
            F_W:     load_c = shifted;
            default: load_c = 32'h0;
         endcase
      end
   end

   // Next-state logic. A new RAM store always replaces the buffer entry; the
   // old entry is committed on the same edge by the RAM process below, so
   // back-to-back stores to one word resolve in program order.
   always_comb begin
      wb_valid_d     = 1'b0;
      wb_idx_d       = wb_idx_q;
      wb_mask_d      = wb_mask_q;
      wb_data_d      = wb_data_q;
      tohost_valid_d = 1'b0;
      tohost_data_d  = tohost_data_q;
      err_d          = err_q | mis_c;
      cycle_cnt_d    = cycle_cnt_q + 32'd1;
      if (store_ok && !is_mmio) begin
         wb_valid_d = 1'b1;
         wb_idx_d   = ram_idx;
         wb_data_d  = writedata << {lane, 3'b000};
         case (memcontrol)
            F_B:     wb_mask_d = 4'b0001 << lane;
            F_H:     wb_mask_d = 4'b0011 << lane;
            default: wb_mask_d = 4'b1111;
         endcase
      end
      if (store_ok && is_mmio && (memcontrol == F_W) && (addr == MMIO_BASE)) begin
         tohost_valid_d = 1'b1;
         tohost_data_d  = writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_valid_q     <= 1'b0;
         wb_idx_q       <= '0;
         wb_mask_q      <= 4'b0000;
         wb_data_q      <= 32'h0;
         tohost_valid_q <= 1'b0;
         tohost_data_q  <= 32'h0;
         err_q          <= 1'b0;
         cycle_cnt_q    <= 32'h0;
      end else begin
         wb_valid_q     <= wb_valid_d;
         wb_idx_q       <= wb_idx_d;
         wb_mask_q      <= wb_mask_d;
         wb_data_q      <= wb_data_d;
         tohost_valid_q <= tohost_valid_d;
         tohost_data_q  <= tohost_data_d;
         err_q          <= err_d;
         cycle_cnt_q    <= cycle_cnt_d;
      end
   end

   // Buffer commit. The array has no reset; a reset edge drops the pending
   // entry instead of committing it.
   always_ff @(posedge clk) begin
      if (reset && wb_valid_q) begin
         for (int i = 0; i < 4; i++) begin
            if (wb_mask_q[i]) begin
               ram_q[wb_idx_q][8*i +: 8] <= wb_data_q[8*i +: 8];
            end
         end
      end
   end

   assign readdata     = load_c;
   assign misaligned   = mis_c;
   assign err_sticky   = err_q;
   assign tohost_valid = tohost_valid_q;
   assign tohost_data  = tohost_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed testbench for data_mem_responder. The driver applies one access
//   per cycle and queues the values the DUT must show in that cycle; a
//   monitor on the falling edge pops the queue and compares.
module tb_data_mem_responder;

   localparam logic [2:0]  OP_B  = 3'b000;
   localparam logic [2:0]  OP_H  = 3'b001;
   localparam logic [2:0]  OP_W  = 3'b010;
   localparam logic [2:0]  OP_BU = 3'b100;
   localparam logic [2:0]  OP_HU = 3'b101;
   localparam logic [31:0] MB    = 32'h8000_0000;

   localparam int K_RD  = 0;
   localparam int K_MIS = 1;
   localparam int K_ERR = 2;
   localparam int K_TV  = 3;
   localparam int K_TD  = 4;

   typedef struct {
      int unsigned cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        memWE;
   logic [2:0]  memcontrol;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        misaligned;
   logic        err_sticky;
   logic        tohost_valid;
   logic [31:0] tohost_data;

   exp_t        sbQ[$];
   int unsigned tbCyc = 0;
   int unsigned rstCyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        endReq = 1'b0;

   data_mem_responder #(.AW(10), .MMIO_BASE(MB)) dut (
      .clk         (clk),
      .reset       (reset),
      .memWE       (memWE),
      .memcontrol  (memcontrol),
      .addr        (addr),
      .writedata   (writedata),
      .readdata    (readdata),
      .misaligned  (misaligned),
      .err_sticky  (err_sticky),
      .tohost_valid(tohost_valid),
      .tohost_data (tohost_data)
   );

   // Free-running clock and a cycle index used to tag expectations.
   always #5 clk = ~clk;

   always @(posedge clk) tbCyc <= tbCyc + 1;

   // Drives one access shortly after the rising edge; it stays stable for the
   // whole cycle so the monitor sees settled combinational outputs.
   task automatic applyStimulus(input logic r, input logic we, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      reset      = r;
      memWE      = we;
      memcontrol = op;
      addr       = a;
      writedata  = d;
   endtask

   task automatic expectVal(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc  = tbCyc;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      sbQ.push_back(e);
   endtask

   function automatic logic [31:0] observed(input int kind);
      case (kind)
         K_RD:    return readdata;
         K_MIS:   return {31'h0, misaligned};
         K_ERR:   return {31'h0, err_sticky};
         K_TV:    return {31'h0, tohost_valid};
         default: return tohost_data;
      endcase
   endfunction

   task automatic checkOutput(input exp_t e);
      logic [31:0] got;
      got = observed(e.kind);
      total++;
      if (got !== e.val) begin
         bad++;
         $display("[TB] FAIL %s (cycle %0d): got 0x%08h expected 0x%08h",
                  e.name, e.cyc, got, e.val);
      end
   endtask

   // Monitor: compares every expectation due this cycle, and on request
   // flushes anything never reached, then prints the summary.
   always @(negedge clk) begin
      while (sbQ.size() > 0 && sbQ[0].cyc <= tbCyc) begin
         checkOutput(sbQ.pop_front());
      end
      if (endReq) begin
         while (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s: never compared, expected 0x%08h", e.name, e.val);
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      reset      = 1'b0;
      memWE      = 1'b0;
      memcontrol = OP_W;
      addr       = 32'h0;
      writedata  = 32'h0;

      // Reset for two edges, then the counter reads 0 in the first cycle.
      applyStimulus(0, 0, OP_W, 32'h0, 32'h0);
      applyStimulus(0, 0, OP_W, 32'h0, 32'h0);
      applyStimulus(1, 0, OP_W, MB + 32'd4, 32'h0);
      rstCyc = tbCyc;
      expectVal(K_RD,  32'h0, "cycle_after_reset");
      expectVal(K_TV,  32'h0, "tohost_valid_reset");
      expectVal(K_TD,  32'h0, "tohost_data_reset");
      expectVal(K_ERR, 32'h0, "err_reset");
      expectVal(K_MIS, 32'h0, "mis_reset");
      applyStimulus(1, 0, OP_W, MB + 32'd4, 32'h0);
      expectVal(K_RD, 32'h1, "cycle_plus1");

      // Word store, then sub-word loads (first one via forwarding).
      applyStimulus(1, 1, OP_W, 32'h10, 32'h1122_3344);
      applyStimulus(1, 0, OP_B, 32'h13, 32'h0);
      expectVal(K_RD, 32'h0000_0011, "lb_fwd_0x13");
      applyStimulus(1, 0, OP_BU, 32'h10, 32'h0);
      expectVal(K_RD, 32'h0000_0044, "lbu_0x10");
      applyStimulus(1, 0, OP_H, 32'h12, 32'h0);
      expectVal(K_RD, 32'h0000_1122, "lh_0x12");

      // Back-to-back stores to the same word.
      applyStimulus(1, 1, OP_W, 32'h20, 32'hFFFF_FFFF);
      applyStimulus(1, 1, OP_B, 32'h21, 32'h0000_0080);
      applyStimulus(1, 0, OP_W, 32'h20, 32'h0);
      expectVal(K_RD, 32'hFFFF_80FF, "lw_merge_0x20");
      applyStimulus(1, 0, OP_B, 32'h21, 32'h0);
      expectVal(K_RD, 32'hFFFF_FF80, "lb_sign_0x21");
      applyStimulus(1, 0, OP_HU, 32'h20, 32'h0);
      expectVal(K_RD, 32'h0000_80FF, "lhu_0x20");
      applyStimulus(1, 1, OP_W, 32'h20, 32'h0102_0304);
      expectVal(K_RD, 32'hFFFF_80FF, "same_cycle_store_unseen");
      applyStimulus(1, 0, OP_H, 32'h22, 32'h0);
      expectVal(K_RD, 32'h0000_0102, "lh_fwd_0x22");
      applyStimulus(1, 0, OP_W, 32'h20, 32'h0);
      expectVal(K_RD, 32'h0102_0304, "lw_0x20");

      // Misaligned accesses and unknown funct3 codes.
      applyStimulus(1, 0, OP_W, 32'h22, 32'h0);
      expectVal(K_MIS, 32'h1, "mis_lw_0x22");
      expectVal(K_RD,  32'h0, "mis_lw_data");
      expectVal(K_ERR, 32'h0, "err_not_yet");
      applyStimulus(1, 1, OP_H, 32'h23, 32'h0000_BEEF);
      expectVal(K_MIS, 32'h1, "mis_sh_0x23");
      expectVal(K_ERR, 32'h1, "err_sticky_set");
      applyStimulus(1, 0, OP_W, 32'h20, 32'h0);
      expectVal(K_RD,  32'h0102_0304, "mis_store_no_effect");
      expectVal(K_MIS, 32'h0, "aligned_no_mis");
      applyStimulus(1, 0, 3'b011, 32'h21, 32'h0);
      expectVal(K_RD,  32'h0, "f011_load_zero");
      expectVal(K_MIS, 32'h0, "f011_no_mis");
      applyStimulus(1, 1, 3'b110, 32'h20, 32'hCAFE_F00D);
      applyStimulus(1, 0, OP_W, 32'h20, 32'h0);
      expectVal(K_RD,  32'h0102_0304, "f110_store_ignored");
      expectVal(K_ERR, 32'h1, "err_still_set");

      // MMIO TOHOST, other offsets, and the cycle counter.
      applyStimulus(1, 1, OP_W, MB, 32'hDEAD_BEEF);
      expectVal(K_TV, 32'h0, "tohost_not_before_edge");
      applyStimulus(1, 0, OP_W, MB, 32'h0);
      expectVal(K_TV, 32'h1, "tohost_pulse");
      expectVal(K_TD, 32'hDEAD_BEEF, "tohost_data");
      expectVal(K_RD, 32'hDEAD_BEEF, "tohost_load");
      applyStimulus(1, 1, OP_B, MB, 32'h0000_0011);
      expectVal(K_TV, 32'h0, "tohost_pulse_one_cycle");
      applyStimulus(1, 0, OP_W, MB + 32'd8, 32'h0);
      expectVal(K_TV, 32'h0, "tohost_sb_no_pulse");
      expectVal(K_TD, 32'hDEAD_BEEF, "tohost_sb_no_data");
      expectVal(K_RD, 32'h0, "mmio_other_load_zero");
      applyStimulus(1, 0, OP_W, MB + 32'd4, 32'h0);
      expectVal(K_RD, tbCyc - rstCyc, "cycle_count_tracks");
      applyStimulus(1, 1, OP_W, 32'h08, 32'h0000_0055);
      applyStimulus(1, 1, OP_W, MB + 32'd8, 32'h9999_9999);
      applyStimulus(1, 0, OP_W, 32'h08, 32'h0);
      expectVal(K_RD, 32'h0000_0055, "mmio_store_not_buffered");

      // Reset discards a pending store and clears the sticky state.
      applyStimulus(1, 1, OP_W, 32'h30, 32'h1234_5678);
      applyStimulus(1, 0, OP_W, 32'h0, 32'h0);
      applyStimulus(1, 1, OP_W, 32'h30, 32'hA5A5_A5A5);
      applyStimulus(0, 0, OP_W, 32'h0, 32'h0);
      applyStimulus(1, 0, OP_W, 32'h30, 32'h0);
      rstCyc = tbCyc;
      expectVal(K_RD,  32'h1234_5678, "reset_drops_pending");
      expectVal(K_ERR, 32'h0, "reset_clears_err");
      expectVal(K_TD,  32'h0, "reset_clears_tohost");
      applyStimulus(1, 0, OP_W, MB + 32'd4, 32'h0);
      expectVal(K_RD, 32'h1, "cycle_restart");

      applyStimulus(1, 0, OP_W, 32'h0, 32'h0);
      applyStimulus(1, 0, OP_W, 32'h0, 32'h0);
      endReq = 1'b1;
   end

endmodule
